// File: rtl/tdc_fill_pkg.sv
// Shared constants and state encoding for the multi-channel TDC data filler.
package tdc_fill_pkg;

    localparam int unsigned NCH_DEF = 4;
    localparam int unsigned DW_DEF  = 32;
    localparam int unsigned AW_DEF  = 16;
    localparam int unsigned TW_DEF  = 12;

    // Dropped-sync counter width; it saturates at all ones.
    localparam int unsigned               SYNC_MISS_W   = 8;
    localparam logic [SYNC_MISS_W-1:0]    SYNC_MISS_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READY   = 3'd1,
        ST_COLLECT = 3'd2,
        ST_DLY     = 3'd3,
        ST_EMIT    = 3'd4
    } state_t;

endpackage

// File: rtl/tdc_chan_capture.sv
// One TDC channel: holds the first rise/fall pair seen in a collect window
// and the mask bit saying it was captured. Exposes next-state values so the
// parent can register a record in the same cycle as the capture.
module tdc_chan_capture
    import tdc_fill_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_strobe,
    input  logic          i_cap_en,
    input  logic [DW-1:0] i_rise,
    input  logic [DW-1:0] i_fall,
    output logic          o_mask_nxt,
    output logic [DW-1:0] o_rise_nxt,
    output logic [DW-1:0] o_fall_nxt
);

    logic          r_mask;
    logic [DW-1:0] r_rise;
    logic [DW-1:0] r_fall;
    logic          w_take;

    assign w_take = i_cap_en && i_strobe && !r_mask;

    // Next-state: clear wins, otherwise first strobe in the window is kept.
    always_comb begin
        o_mask_nxt = r_mask;
        o_rise_nxt = r_rise;
        o_fall_nxt = r_fall;
        if (i_clr) begin
            o_mask_nxt = 1'b0;
            o_rise_nxt = '0;
            o_fall_nxt = '0;
        end else if (w_take) begin
            o_mask_nxt = 1'b1;
            o_rise_nxt = i_rise;
            o_fall_nxt = i_fall;
        end
    end

    // Capture registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mask <= 1'b0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_mask <= o_mask_nxt;
            r_rise <= o_rise_nxt;
            r_fall <= o_fall_nxt;
        end
    end

endmodule

// File: rtl/tdc_fill_mc.sv
// Multi-channel TDC data filler: per angle sync, collects one rise/fall record
// per channel within a window, zero-fills missing channels and streams the
// NCH records with the latched encoder angles over valid/ready.
module tdc_fill_mc
    import tdc_fill_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEF,
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned AW  = AW_DEF,
    parameter int unsigned TW  = TW_DEF
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst_n,
    input  logic                                    i_tdcmodule_en,
    input  logic                                    i_angle_sync,
    input  logic                                    i_tdcsync_ready,
    input  logic [AW-1:0]                           i_code_angle1,
    input  logic [AW-1:0]                           i_code_angle2,
    input  logic [TW-1:0]                           i_timeout,
    input  logic [TW-1:0]                           i_nosync_dly,
    input  logic [NCH-1:0]                          i_tdc_newsig,
    input  logic [NCH*DW-1:0]                       i_rise_data,
    input  logic [NCH*DW-1:0]                       i_fall_data,
    output logic                                    o_valid,
    input  logic                                    i_ready,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] o_ch,
    output logic                                    o_fill,
    output logic [AW-1:0]                           o_code_angle1,
    output logic [AW-1:0]                           o_code_angle2,
    output logic [DW-1:0]                           o_rise_data,
    output logic [DW-1:0]                           o_fall_data,
    output logic [SYNC_MISS_W-1:0]                  o_sync_miss,
    output logic                                    o_busy
);

    localparam int unsigned    CW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0]  LAST_CH = CW'(NCH - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [TW-1:0]          r_cnt;
    logic [NCH-1:0]         w_mask_d;
    logic [DW-1:0]          w_rise_d [NCH];
    logic [DW-1:0]          w_fall_d [NCH];
    logic                   w_sync_ok;
    logic                   w_clr;
    logic                   w_cap_en;
    logic                   w_accept;
    logic                   w_load;
    logic [CW-1:0]          w_ch_inc;
    logic [CW-1:0]          w_sel;
    logic                   r_valid;
    logic [CW-1:0]          r_ch;
    logic                   r_fill;
    logic [DW-1:0]          r_rise;
    logic [DW-1:0]          r_fall;
    logic [AW-1:0]          r_ang1;
    logic [AW-1:0]          r_ang2;
    logic [SYNC_MISS_W-1:0] r_miss;

    assign w_sync_ok = i_tdcmodule_en && (r_state == ST_READY) && i_angle_sync;
    assign w_clr     = (r_state == ST_IDLE) || w_sync_ok;
    assign w_cap_en  = (r_state == ST_COLLECT);
    assign w_accept  = r_valid && i_ready;
    assign w_ch_inc  = r_ch + 1'b1;

    // Entering EMIT presents channel 0; captures are frozen in EMIT, so the
    // next-state view of the capture bank equals its registered contents.
    assign w_sel  = (r_state == ST_EMIT) ? w_ch_inc : '0;
    assign w_load = i_tdcmodule_en &&
                    ((((r_state == ST_COLLECT) || (r_state == ST_DLY)) && (w_state_nxt == ST_EMIT)) ||
                     ((r_state == ST_EMIT) && w_accept && (r_ch != LAST_CH)));

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_ch
            tdc_chan_capture #(.DW(DW)) u_cap (
                .i_clk      (i_clk),
                .i_rst_n    (i_rst_n),
                .i_clr      (w_clr),
                .i_strobe   (i_tdc_newsig[c]),
                .i_cap_en   (w_cap_en),
                .i_rise     (i_rise_data[c*DW +: DW]),
                .i_fall     (i_fall_data[c*DW +: DW]),
                .o_mask_nxt (w_mask_d[c]),
                .o_rise_nxt (w_rise_d[c]),
                .o_fall_nxt (w_fall_d[c])
            );
        end
    endgenerate

    // Next-state logic; losing enable always returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (!i_tdcmodule_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_nxt = ST_READY;
                ST_READY:   if (i_angle_sync) w_state_nxt = i_tdcsync_ready ? ST_COLLECT : ST_DLY;
                ST_COLLECT: if ((&w_mask_d) || (r_cnt == i_timeout)) w_state_nxt = ST_EMIT;
                ST_DLY:     if (r_cnt == i_nosync_dly) w_state_nxt = ST_EMIT;
                ST_EMIT:    if (w_accept && (r_ch == LAST_CH)) w_state_nxt = ST_READY;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register and shared window/delay counter (cleared on any transition).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (((r_state == ST_COLLECT) || (r_state == ST_DLY)) && (w_state_nxt == r_state))
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end

    // Angle latch on an accepted sync; saturating count of dropped syncs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ang1 <= '0;
            r_ang2 <= '0;
            r_miss <= '0;
        end else begin
            if (w_sync_ok) begin
                r_ang1 <= i_code_angle1;
                r_ang2 <= i_code_angle2;
            end
            if (i_angle_sync && (r_state != ST_READY) && (r_miss != SYNC_MISS_MAX))
                r_miss <= r_miss + 1'b1;
        end
    end

    // Registered output record; held stable until accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_ch    <= '0;
            r_fill  <= 1'b0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else if (!i_tdcmodule_en) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_ch    <= w_sel;
            r_fill  <= ~w_mask_d[w_sel];
            r_rise  <= w_mask_d[w_sel] ? w_rise_d[w_sel] : '0;
            r_fall  <= w_mask_d[w_sel] ? w_fall_d[w_sel] : '0;
        end else if ((r_state == ST_EMIT) && w_accept) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid       = r_valid;
    assign o_ch          = r_ch;
    assign o_fill        = r_fill;
    assign o_rise_data   = r_rise;
    assign o_fall_data   = r_fall;
    assign o_code_angle1 = r_ang1;
    assign o_code_angle2 = r_ang2;
    assign o_sync_miss   = r_miss;
    assign o_busy        = (r_state == ST_COLLECT) || (r_state == ST_DLY) || (r_state == ST_EMIT);

endmodule

// File: tb/tb_tdc_fill_mc.sv
// Directed bench for tdc_fill_mc with a record scoreboard.
module tb_tdc_fill_mc;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 16;
    localparam int unsigned TW  = 12;

    typedef struct {
        logic [1:0]  ch;
        logic        fill;
        logic [31:0] rise;
        logic [31:0] fall;
        logic [15:0] a1;
        logic [15:0] a2;
    } rec_t;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_tdcmodule_en;
    logic              i_angle_sync;
    logic              i_tdcsync_ready;
    logic [AW-1:0]     i_code_angle1;
    logic [AW-1:0]     i_code_angle2;
    logic [TW-1:0]     i_timeout;
    logic [TW-1:0]     i_nosync_dly;
    logic [NCH-1:0]    i_tdc_newsig;
    logic [NCH*DW-1:0] i_rise_data;
    logic [NCH*DW-1:0] i_fall_data;
    logic              o_valid;
    logic              i_ready;
    logic [1:0]        o_ch;
    logic              o_fill;
    logic [AW-1:0]     o_code_angle1;
    logic [AW-1:0]     o_code_angle2;
    logic [DW-1:0]     o_rise_data;
    logic [DW-1:0]     o_fall_data;
    logic [7:0]        o_sync_miss;
    logic              o_busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    rec_t sb[$];

    always #5 i_clk = ~i_clk;

    tdc_fill_mc #(.NCH(NCH), .DW(DW), .AW(AW), .TW(TW)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_tdcmodule_en  (i_tdcmodule_en),
        .i_angle_sync    (i_angle_sync),
        .i_tdcsync_ready (i_tdcsync_ready),
        .i_code_angle1   (i_code_angle1),
        .i_code_angle2   (i_code_angle2),
        .i_timeout       (i_timeout),
        .i_nosync_dly    (i_nosync_dly),
        .i_tdc_newsig    (i_tdc_newsig),
        .i_rise_data     (i_rise_data),
        .i_fall_data     (i_fall_data),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_ch            (o_ch),
        .o_fill          (o_fill),
        .o_code_angle1   (o_code_angle1),
        .o_code_angle2   (o_code_angle2),
        .o_rise_data     (o_rise_data),
        .o_fall_data     (o_fall_data),
        .o_sync_miss     (o_sync_miss),
        .o_busy          (o_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) tick();
    endtask

    task automatic push(input int c, input logic f, input logic [31:0] r, input logic [31:0] fl,
                        input logic [15:0] a1, input logic [15:0] a2);
        rec_t e;
        e.ch = 2'(c); e.fill = f; e.rise = r; e.fall = fl; e.a1 = a1; e.a2 = a2;
        sb.push_back(e);
    endtask

    task automatic hit(input int c, input logic [31:0] r, input logic [31:0] f);
        i_rise_data[c*32 +: 32] = r;
        i_fall_data[c*32 +: 32] = f;
        i_tdc_newsig[c]         = 1'b1;
    endtask

    // Sync is driven during cycle 0; returns at cycle 1 with the angle inputs scrambled.
    task automatic do_sync(input logic arm, input logic [15:0] a1, input logic [15:0] a2);
        i_angle_sync    = 1'b1;
        i_tdcsync_ready = arm;
        i_code_angle1   = a1;
        i_code_angle2   = a2;
        cyc = 0;
        tick();
        i_angle_sync  = 1'b0;
        i_code_angle1 = ~a1;
        i_code_angle2 = ~a2;
    endtask

    // Accept n records, stalling stall_len cycles on channel stall_ch.
    task automatic drain(input int n, input int stall_ch, input int stall_len);
        int   got    = 0;
        int   waited = 0;
        int   stalls = 0;
        rec_t e;
        rec_t held;
        while (got < n && waited < 1000) begin
            if (o_valid) begin
                if (int'(o_ch) == stall_ch && stalls < stall_len) begin
                    i_ready = 1'b0;
                    if (stalls == 0) begin
                        held.ch = o_ch; held.fill = o_fill; held.rise = o_rise_data;
                        held.fall = o_fall_data; held.a1 = o_code_angle1; held.a2 = o_code_angle2;
                    end else begin
                        chk("stall_ch",   64'(o_ch),        64'(held.ch));
                        chk("stall_rise", 64'(o_rise_data), 64'(held.rise));
                        chk("stall_fill", 64'(o_fill),      64'(held.fill));
                        chk("stall_a1",   64'(o_code_angle1), 64'(held.a1));
                    end
                    stalls++;
                end else begin
                    i_ready = 1'b1;
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 64'(sb.size()), 64'd1);
                    end else begin
                        e = sb.pop_front();
                        chk("rec_ch",   64'(o_ch),          64'(e.ch));
                        chk("rec_fill", 64'(o_fill),        64'(e.fill));
                        chk("rec_rise", 64'(o_rise_data),   64'(e.rise));
                        chk("rec_fall", 64'(o_fall_data),   64'(e.fall));
                        chk("rec_a1",   64'(o_code_angle1), 64'(e.a1));
                        chk("rec_a2",   64'(o_code_angle2), 64'(e.a2));
                    end
                    got++;
                end
            end else begin
                i_ready = 1'b1;
            end
            tick();
            waited++;
        end
        if (got < n) chk("drain_timeout", 64'(got), 64'(n));
    endtask

    initial begin
        i_rst_n         = 1'b0;
        i_tdcmodule_en  = 1'b0;
        i_angle_sync    = 1'b0;
        i_tdcsync_ready = 1'b0;
        i_code_angle1   = '0;
        i_code_angle2   = '0;
        i_timeout       = 12'd150;
        i_nosync_dly    = 12'd80;
        i_tdc_newsig    = '0;
        i_rise_data     = '0;
        i_fall_data     = '0;
        i_ready         = 1'b1;
        tick(); tick();
        i_rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_fill",  64'(o_fill),  64'd0);
        chk("rst_ch",    64'(o_ch),    64'd0);
        chk("rst_rise",  64'(o_rise_data), 64'd0);
        chk("rst_fall",  64'(o_fall_data), 64'd0);
        chk("rst_a1",    64'(o_code_angle1), 64'd0);
        chk("rst_a2",    64'(o_code_angle2), 64'd0);
        chk("rst_miss",  64'(o_sync_miss), 64'd0);
        chk("rst_busy",  64'(o_busy),  64'd0);

        i_tdcmodule_en = 1'b1;
        tick(); tick();
        chk("ready_busy", 64'(o_busy), 64'd0);

        // All four channels captured, staggered; duplicate ch0 strobe ignored; ch2 stalled.
        do_sync(1'b1, 16'h1234, 16'h5678);
        chk("t1_busy", 64'(o_busy), 64'd1);
        for (int c = 0; c < 4; c++)
            push(c, 1'b0, 32'h11 * (c + 1), (32'h11 * (c + 1)) ^ 32'hFFFF0000, 16'h1234, 16'h5678);
        wait_cyc(3); hit(0, 32'h11, 32'h11 ^ 32'hFFFF0000); tick(); i_tdc_newsig = '0;
        hit(0, 32'h99, 32'h99); tick(); i_tdc_newsig = '0;
        wait_cyc(5); hit(1, 32'h22, 32'h22 ^ 32'hFFFF0000); tick(); i_tdc_newsig = '0;
        wait_cyc(7); hit(2, 32'h33, 32'h33 ^ 32'hFFFF0000); tick(); i_tdc_newsig = '0;
        wait_cyc(9); hit(3, 32'h44, 32'h44 ^ 32'hFFFF0000);
        chk("t1_valid_c9", 64'(o_valid), 64'd0);
        tick(); i_tdc_newsig = '0;
        chk("t1_valid_c10", 64'(o_valid), 64'd1);
        drain(4, 2, 5);
        chk("t1_done_valid", 64'(o_valid), 64'd0);
        chk("t1_done_busy",  64'(o_busy),  64'd0);
        chk("t1_miss",       64'(o_sync_miss), 64'd0);

        // Only ch1 hits; timeout at 150; a sync during COLLECT is dropped.
        do_sync(1'b1, 16'hAAAA, 16'h0F0F);
        push(0, 1'b1, 32'h0, 32'h0, 16'hAAAA, 16'h0F0F);
        push(1, 1'b0, 32'hABCD, 32'hDCBA, 16'hAAAA, 16'h0F0F);
        push(2, 1'b1, 32'h0, 32'h0, 16'hAAAA, 16'h0F0F);
        push(3, 1'b1, 32'h0, 32'h0, 16'hAAAA, 16'h0F0F);
        wait_cyc(5); hit(1, 32'hABCD, 32'hDCBA); tick(); i_tdc_newsig = '0;
        wait_cyc(20); i_angle_sync = 1'b1; tick(); i_angle_sync = 1'b0;
        chk("t2_miss1", 64'(o_sync_miss), 64'd1);
        wait_cyc(151);
        chk("t2_valid_c151", 64'(o_valid), 64'd0);
        tick();
        chk("t2_valid_c152", 64'(o_valid), 64'd1);
        drain(4, -1, 0);

        // Not armed: delay 80 then all filled; strobe in DLY ignored; 300 syncs saturate.
        i_ready = 1'b0;
        do_sync(1'b0, 16'h4242, 16'h2424);
        for (int c = 0; c < 4; c++) push(c, 1'b1, 32'h0, 32'h0, 16'h4242, 16'h2424);
        wait_cyc(10); hit(0, 32'hDEAD, 32'hBEEF); tick(); i_tdc_newsig = '0;
        wait_cyc(81);
        chk("t3_valid_c81", 64'(o_valid), 64'd0);
        tick();
        chk("t3_valid_c82", 64'(o_valid), 64'd1);
        i_angle_sync = 1'b1;
        repeat (300) tick();
        i_angle_sync = 1'b0;
        chk("t3_miss_sat", 64'(o_sync_miss), 64'd255);
        chk("t3_hold_valid", 64'(o_valid), 64'd1);
        chk("t3_hold_ch",    64'(o_ch),    64'd0);
        chk("t3_hold_fill",  64'(o_fill),  64'd1);
        drain(4, -1, 0);

        // Enable dropped mid-EMIT: record set discarded, then a clean set after re-enable.
        do_sync(1'b1, 16'h7777, 16'h8888);
        for (int c = 0; c < 4; c++) push(c, 1'b0, 32'hA0 + c, 32'hB0 + c, 16'h7777, 16'h8888);
        wait_cyc(2);
        for (int c = 0; c < 4; c++) hit(c, 32'hA0 + c, 32'hB0 + c);
        tick(); i_tdc_newsig = '0;
        chk("t5_valid_c3", 64'(o_valid), 64'd1);
        drain(1, -1, 0);
        chk("t5_ch1_shown", 64'(o_ch), 64'd1);
        i_tdcmodule_en = 1'b0;
        i_ready        = 1'b0;
        tick();
        chk("t5_drop_valid", 64'(o_valid), 64'd0);
        chk("t5_drop_busy",  64'(o_busy),  64'd0);
        sb.delete();
        i_tdcmodule_en = 1'b1;
        tick(); tick();
        chk("t5_reen_busy", 64'(o_busy), 64'd0);
        do_sync(1'b1, 16'h1357, 16'h2468);
        for (int c = 0; c < 4; c++) push(c, 1'b0, 32'hC0 + c, 32'hD0 + c, 16'h1357, 16'h2468);
        wait_cyc(4);
        for (int c = 0; c < 4; c++) hit(c, 32'hC0 + c, 32'hD0 + c);
        tick(); i_tdc_newsig = '0;
        chk("t5_valid_c5", 64'(o_valid), 64'd1);
        drain(4, -1, 0);
        chk("t5_sb_empty", 64'(sb.size()), 64'd0);
        chk("t5_miss_kept", 64'(o_sync_miss), 64'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
